// File: rtl/serial_stream_addsub.sv
// ============================================================================
//  Module   : serial_stream_addsub
//  Brief    : Digit-serial adder/subtractor, LSD first, one-cycle registered
//             outputs. Define SERIAL_STREAM_ADDSUB_OVF_EN to build the signed
//             overflow flag; otherwise ovf is tied low.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module serial_stream_addsub #(
    parameter int DIGIT_W   = 1,
    parameter int FRAME_LEN = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               sof,
    input  logic               sub,
    input  logic [DIGIT_W-1:0] A,
    input  logic [DIGIT_W-1:0] B,
    output logic [DIGIT_W-1:0] Y,
    output logic               out_valid,
    output logic               out_last,
    output logic               carry_out,
    output logic               ovf
);

    localparam int                 c_CNT_W    = $clog2(FRAME_LEN);
    localparam logic [c_CNT_W-1:0] c_LAST_IDX = c_CNT_W'(FRAME_LEN - 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_carry;
    logic               r_mode;

    logic               w_first;
    logic [c_CNT_W-1:0] w_idx;
    logic               w_mode;
    logic               w_cin;
    logic               w_last;
    logic [DIGIT_W-1:0] w_b_eff;
    logic [DIGIT_W:0]   w_sum;

    // A first digit restarts the word: index 0, fresh mode, carry-in = sub.
    assign w_first = in_valid && ((r_state == IDLE) || sof);
    assign w_idx   = w_first ? '0  : r_cnt;
    assign w_mode  = w_first ? sub : r_mode;
    assign w_cin   = w_first ? sub : r_carry;
    assign w_last  = (w_idx == c_LAST_IDX);
    assign w_b_eff = w_mode ? ~B : B;
    assign w_sum   = {1'b0, A} + {1'b0, w_b_eff} + {{DIGIT_W{1'b0}}, w_cin};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_carry   <= 1'b0;
            r_mode    <= 1'b0;
            Y         <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            carry_out <= 1'b0;
        end else begin
            out_valid <= in_valid;
            out_last  <= in_valid && w_last;
            if (in_valid) begin
                Y       <= w_sum[DIGIT_W-1:0];
                r_mode  <= w_mode;
                r_carry <= w_sum[DIGIT_W];
                if (w_last) begin
                    r_state   <= IDLE;
                    r_cnt     <= '0;
                    carry_out <= w_sum[DIGIT_W];
                end else begin
                    r_state <= ACTIVE;
                    r_cnt   <= w_idx + c_CNT_W'(1);
                end
            end
        end
    end

`ifdef SERIAL_STREAM_ADDSUB_OVF_EN
    // Carry into the MSB recovered from the sum bit: s = a ^ b ^ cin.
    logic w_msb_cin;
    assign w_msb_cin = w_sum[DIGIT_W-1] ^ A[DIGIT_W-1] ^ w_b_eff[DIGIT_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (in_valid && w_last) begin
            ovf <= w_msb_cin ^ w_sum[DIGIT_W];
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_stream_addsub.sv
// ============================================================================
//  Module   : tb_serial_stream_addsub
//  Brief    : Self-checking bench: word-level arithmetic model plus directed
//             literal checks, two DUT configurations (1x4 and 4x2).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_serial_stream_addsub;

`ifdef SERIAL_STREAM_ADDSUB_OVF_EN
    localparam bit c_OVF_EN = 1'b1;
`else
    localparam bit c_OVF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, iv0, sof0, sub0;
    logic [0:0] a0, b0, y0;
    logic       ov0, ol0, co0, of0;

    logic       rst1, iv1, sof1, sub1;
    logic [3:0] a1, b1, y1;
    logic       ov1, ol1, co1, of1;

    serial_stream_addsub #(.DIGIT_W(1), .FRAME_LEN(4)) dut0 (
        .clk(clk), .rst(rst0), .in_valid(iv0), .sof(sof0), .sub(sub0),
        .A(a0), .B(b0), .Y(y0), .out_valid(ov0), .out_last(ol0),
        .carry_out(co0), .ovf(of0)
    );

    serial_stream_addsub #(.DIGIT_W(4), .FRAME_LEN(2)) dut1 (
        .clk(clk), .rst(rst1), .in_valid(iv1), .sof(sof1), .sub(sub1),
        .A(a1), .B(b1), .Y(y1), .out_valid(ov1), .out_last(ol1),
        .carry_out(co1), .ovf(of1)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Word-level model: operands accumulate as integers, each output digit is
    // the matching slice of the full-width sum of the digits seen so far.
    bit          m_act  [2];
    int          m_idx  [2];
    bit          m_mode [2];
    logic [63:0] m_aw   [2];
    logic [63:0] m_bw   [2];
    logic [63:0] e_y    [2];
    bit          e_ov [2], e_ol [2], e_co [2], e_of [2];
    bit          started = 1'b0;

    task automatic model_step(input int k, input int dw, input int fl, input bit r,
                              input bit v, input bit s, input bit sb,
                              input logic [63:0] a, input logic [63:0] b);
        logic [63:0] mask, tot, dmask;
        int          nb;
        bit          sa, sbb, sr;
        if (r) begin
            m_act[k] = 0; m_idx[k] = 0; m_mode[k] = 0;
            e_y[k] = '0; e_ov[k] = 0; e_ol[k] = 0; e_co[k] = 0; e_of[k] = 0;
            return;
        end
        e_ov[k] = v;
        e_ol[k] = 0;
        if (!v) return;
        if (!m_act[k] || s) begin
            m_idx[k] = 0; m_mode[k] = sb; m_aw[k] = '0; m_bw[k] = '0;
        end
        m_aw[k] = m_aw[k] | (a << (m_idx[k] * dw));
        m_bw[k] = m_bw[k] | (b << (m_idx[k] * dw));
        nb    = (m_idx[k] + 1) * dw;
        mask  = (64'd1 << nb) - 64'd1;
        dmask = (64'd1 << dw) - 64'd1;
        tot   = m_aw[k] + (m_mode[k] ? (~m_bw[k] & mask) : m_bw[k]) + 64'(m_mode[k]);
        e_y[k] = (tot >> (m_idx[k] * dw)) & dmask;
        if (m_idx[k] == fl - 1) begin
            e_ol[k] = 1;
            e_co[k] = ((tot >> nb) & 64'd1) != 0;
            if (c_OVF_EN) begin
                sa  = ((m_aw[k] >> (nb - 1)) & 64'd1) != 0;
                sbb = ((m_bw[k] >> (nb - 1)) & 64'd1) != 0;
                sr  = ((tot     >> (nb - 1)) & 64'd1) != 0;
                e_of[k] = m_mode[k] ? ((sa != sbb) && (sr != sa)) : ((sa == sbb) && (sr != sa));
            end
            m_act[k] = 0;
            m_idx[k] = 0;
        end else begin
            m_act[k] = 1;
            m_idx[k]++;
        end
    endtask

    always @(posedge clk) begin
        model_step(0, 1, 4, rst0, iv0, sof0, sub0, 64'(a0), 64'(b0));
        model_step(1, 4, 2, rst1, iv1, sof1, sub1, 64'(a1), 64'(b1));
        if (rst0 && rst1) started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m0_y",  64'(y0),  e_y[0]);
            chk("m0_ov", 64'(ov0), 64'(e_ov[0]));
            chk("m0_ol", 64'(ol0), 64'(e_ol[0]));
            chk("m0_co", 64'(co0), 64'(e_co[0]));
            chk("m0_of", 64'(of0), 64'(e_of[0]));
            chk("m1_y",  64'(y1),  e_y[1]);
            chk("m1_ov", 64'(ov1), 64'(e_ov[1]));
            chk("m1_ol", 64'(ol1), 64'(e_ol[1]));
            chk("m1_co", 64'(co1), 64'(e_co[1]));
            chk("m1_of", 64'(of1), 64'(e_of[1]));
        end
    end

    task automatic cyc0(input bit r, input bit v, input bit s, input bit sb,
                        input logic a, input logic b);
        @(negedge clk);
        rst0 = r; iv0 = v; sof0 = s; sub0 = sb; a0 = a; b0 = b;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc1(input bit r, input bit v, input bit s, input bit sb,
                        input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        rst1 = r; iv1 = v; sof1 = s; sub1 = sb; a1 = a; b1 = b;
        @(posedge clk);
        #1;
    endtask

    task automatic word0(input int a, input int b, input bit sb,
                         output int y, output int olpat, output bit co, output bit of);
        y = 0; olpat = 0; co = 0; of = 0;
        for (int i = 0; i < 4; i++) begin
            cyc0(0, 1, (i == 0), sb, a[i], b[i]);
            y     = y | (int'(y0) << i);
            olpat = olpat | (int'(ol0) << i);
            co    = co0;
            of    = of0;
        end
    endtask

    initial begin
        int y, olp, gy;
        bit co, of;
        rst0 = 1; iv0 = 0; sof0 = 0; sub0 = 0; a0 = 0; b0 = 0;
        rst1 = 1; iv1 = 0; sof1 = 0; sub1 = 0; a1 = 0; b1 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_y0", 64'(y0), 0);
        chk("rst_ov0", 64'(ov0), 0);
        chk("rst_ol0", 64'(ol0), 0);
        chk("rst_co0", 64'(co0), 0);
        chk("rst_y1", 64'(y1), 0);
        chk("rst_of1", 64'(of1), 0);
        @(negedge clk);
        rst1 = 0;

        word0(3, 5, 0, y, olp, co, of);
        chk("add_3p5_y", 64'(y), 8);
        chk("add_3p5_last", 64'(olp), 8);
        chk("add_3p5_co", 64'(co), 0);
        chk("add_3p5_ovf", 64'(of), 0);
        word0(5, 3, 1, y, olp, co, of);
        chk("sub_5m3_y", 64'(y), 2);
        chk("sub_5m3_co", 64'(co), 1);
        word0(3, 5, 1, y, olp, co, of);
        chk("sub_3m5_y", 64'(y), 14);
        chk("sub_3m5_co", 64'(co), 0);
        word0(7, 1, 0, y, olp, co, of);
        chk("add_7p1_y", 64'(y), 8);
        chk("add_7p1_ovf", 64'(of), 64'(c_OVF_EN));
        word0(15, 1, 0, y, olp, co, of);
        chk("add_15p1_y", 64'(y), 0);
        chk("add_15p1_co", 64'(co), 1);
        chk("add_15p1_ovf", 64'(of), 0);

        // 3+5 with a two-cycle gap after digit 1 and sub toggled in the gap
        gy = 0;
        cyc0(0, 1, 1, 0, 1, 1); gy = gy | int'(y0);
        cyc0(0, 1, 0, 0, 1, 0); gy = gy | (int'(y0) << 1);
        cyc0(0, 0, 0, 1, 0, 0); chk("gap_ov_a", 64'(ov0), 0);
        cyc0(0, 0, 0, 1, 0, 0); chk("gap_ov_b", 64'(ov0), 0);
        cyc0(0, 1, 0, 1, 0, 1); gy = gy | (int'(y0) << 2);
        cyc0(0, 1, 0, 1, 0, 0); gy = gy | (int'(y0) << 3);
        chk("gap_y", 64'(gy), 8);
        chk("gap_last", 64'(ol0), 1);
        chk("gap_co", 64'(co0), 0);

        // abandon a word after two digits, restart with sof on 1+1
        cyc0(0, 1, 1, 0, 1, 1); chk("abn_ol_a", 64'(ol0), 0);
        cyc0(0, 1, 0, 0, 1, 0); chk("abn_ol_b", 64'(ol0), 0);
        word0(1, 1, 0, y, olp, co, of);
        chk("abn_new_y", 64'(y), 2);
        chk("abn_new_last", 64'(olp), 8);
        chk("abn_new_co", 64'(co), 0);
        cyc0(0, 0, 0, 0, 0, 0);

        // 4-bit digits: 0x3C + 0x05
        cyc1(0, 1, 1, 0, 4'hC, 4'h5); chk("w4_d0_y", 64'(y1), 1);
        chk("w4_d0_ol", 64'(ol1), 0);
        cyc1(0, 1, 0, 0, 4'h3, 4'h0); chk("w4_d1_y", 64'(y1), 4);
        chk("w4_d1_ol", 64'(ol1), 1);
        chk("w4_d1_co", 64'(co1), 0);
        // reset mid-word (with in_valid high), then 0x11 + 0x22 from carry-in 0
        cyc1(0, 1, 1, 0, 4'hC, 4'h5); chk("w4_pre_y", 64'(y1), 1);
        cyc1(1, 1, 0, 0, 4'h3, 4'h0); chk("w4_rst_ov", 64'(ov1), 0);
        chk("w4_rst_y", 64'(y1), 0);
        cyc1(0, 1, 0, 0, 4'h1, 4'h2); chk("w4_post_y0", 64'(y1), 3);
        chk("w4_post_ol0", 64'(ol1), 0);
        cyc1(0, 1, 0, 0, 4'h1, 4'h2); chk("w4_post_y1", 64'(y1), 3);
        chk("w4_post_ol1", 64'(ol1), 1);
        chk("w4_post_co", 64'(co1), 0);

        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst0 = ($urandom_range(0, 99) == 0);
            iv0  = ($urandom_range(0, 3) != 0);
            sof0 = ($urandom_range(0, 15) == 0);
            sub0 = 1'($urandom);
            a0   = 1'($urandom);
            b0   = 1'($urandom);
            rst1 = ($urandom_range(0, 99) == 0);
            iv1  = ($urandom_range(0, 3) != 0);
            sof1 = ($urandom_range(0, 15) == 0);
            sub1 = 1'($urandom);
            a1   = 4'($urandom);
            b1   = 4'($urandom);
        end
        @(negedge clk);
        rst0 = 0; iv0 = 0; rst1 = 0; iv1 = 0;
        repeat (3) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serial_stream_addsub.md
SERIAL_STREAM_ADDSUB -- requirements
Module: serial_stream_addsub

Interface
REQ-001 The block SHALL have parameter DIGIT_W, default 1, meaning the number of bits added per accepted digit (1..16).
REQ-002 The block SHALL have parameter FRAME_LEN, default 8, meaning the number of digits per word (2..256).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous reset, active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the digit on A/B is presented this cycle.
REQ-006 The block SHALL have port sof, input, 1 bit: the presented digit is the first (least significant) digit of a new word.
REQ-007 The block SHALL have port sub, input, 1 bit: 0 selects A+B, 1 selects A-B; sampled on the first digit of a word only.
REQ-008 The block SHALL have ports A and B, input, DIGIT_W bits: operand digits, least significant digit first.
REQ-009 The block SHALL have port Y, output, DIGIT_W bits: the result digit.
REQ-010 The block SHALL have port out_valid, output, 1 bit: Y carries a result digit.
REQ-011 The block SHALL have port out_last, output, 1 bit: Y is the final digit of a word.
REQ-012 The block SHALL have port carry_out, output, 1 bit: the word's final carry (no-borrow flag when sub=1); meaningful only with out_last.
REQ-013 The block SHALL have port ovf, output, 1 bit: signed two's-complement overflow of the word; meaningful only with out_last.

Function
REQ-014 The block SHALL implement an FSM with states IDLE (no word in progress) and ACTIVE (word in progress), plus a digit counter cnt of ceil(log2(FRAME_LEN)) bits.
REQ-015 IDLE->ACTIVE SHALL occur on in_valid=1 when the accepted digit is not the last digit; ACTIVE->IDLE SHALL occur on acceptance of digit FRAME_LEN-1; in_valid=0 SHALL hold the state, cnt and carry unchanged.
REQ-016 A digit SHALL be treated as first when in_valid=1 and either state=IDLE or sof=1; sof=1 in ACTIVE SHALL abandon the current word without asserting out_last for it, and SHALL restart at cnt=0.
REQ-017 On a first digit the block SHALL latch sub into a mode register and SHALL use carry-in = sub; on later digits it SHALL use the stored carry and the latched mode, and SHALL ignore changes on sub.
REQ-018 Each accepted digit SHALL compute {c, s} = A + (mode ? ~B : B) + carry-in at DIGIT_W+1 bits; c SHALL be stored as the next carry-in.
REQ-019 Outputs SHALL be registered with exactly one cycle of latency: Y<=s, out_valid<=in_valid, and out_last<=1 only for the accepted digit with effective index FRAME_LEN-1.
REQ-020 carry_out SHALL update to c together with out_last=1 and hold its value otherwise.
REQ-021 When out_valid=0, Y SHALL hold its previous value.
REQ-022 After the last digit, cnt SHALL wrap to 0; a back-to-back next digit SHALL be a first digit with no idle cycle required.

Reset
REQ-023 While rst=1 at a clock edge, state SHALL be IDLE and cnt, carry, mode, Y, out_valid, out_last, carry_out and ovf SHALL be 0; rst SHALL take priority over in_valid.
REQ-024 rst asserted mid-word SHALL discard the partial word; the next accepted digit after release SHALL be a first digit.

Configuration
REQ-025 With macro SERIAL_STREAM_ADDSUB_OVF_EN defined, ovf SHALL update with out_last=1 to (carry into digit MSB) XOR (carry out of digit MSB) of the last digit and hold otherwise.
REQ-026 Without SERIAL_STREAM_ADDSUB_OVF_EN, ovf SHALL be constant 0 and no overflow logic SHALL be built.

Verification
REQ-027 DIGIT_W=1, FRAME_LEN=4, sub=0, A=3 (bits 1,1,0,0) B=5 (1,0,1,0) on consecutive cycles -> Y=0,0,0,1 one cycle later, out_last on 4th, carry_out=0, ovf=0.
REQ-028 Same configuration, sub=1, A=5 B=3 -> Y=0,1,0,0 (2), carry_out=1; then sub=1, A=3 B=5 -> Y=0,1,1,1 (-2), carry_out=0.
REQ-029 Same configuration, A=7 B=1 add -> Y=0,0,0,1, ovf=1 with OVF_EN and ovf=0 without; A=15 B=1 -> Y=0000, carry_out=1, ovf=0.
REQ-030 Same configuration, 3+5 with in_valid low for 2 cycles between digits 1 and 2, sub toggled during the gap -> identical Y sequence, out_valid low during gaps, result unchanged.
REQ-031 Same configuration, two digits of a word then sof=1 with a new word 1+1 -> no out_last for the abandoned word; new word gives Y=0,1,0,0, carry_out=0.
REQ-032 DIGIT_W=4, FRAME_LEN=2, 0x3C+0x05 as digits C,3 and 5,0 -> Y=1 then 4, carry_out=0; rst pulse after the first digit -> out_valid=0 next cycle, and a following word computes from carry-in 0.
